// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default pointer sizing and Gray/binary conversion helpers.
// Helpers work on a fixed maximum width; callers zero-extend and truncate to their own pointer width.
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 9;
    localparam int PTR_MAX_W       = 32;

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    // Leading zeros of a zero-extended Gray code stay zero in binary, so one width serves all.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_w2r_ah.sv
// Two-flop synchronizer carrying the Gray write pointer into the read clock domain.
module sync_w2r_ah #(
    parameter int WIDTH = 10
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [WIDTH-1:0] wptr,
    output logic [WIDTH-1:0] rq2_wptr
);

    logic [WIDTH-1:0] rq1_wptr;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rq1_wptr <= '0;
            rq2_wptr <= '0;
        end else begin
            rq1_wptr <= wptr;
            rq2_wptr <= rq1_wptr;
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: read pointers, RAM read address,
// registered empty/almost-empty/fill-count flags and a sticky underflow flag.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH    = FIFO_ADDR_WIDTH,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  rinc,
    input  logic                  rclr_err,
    input  logic [ADDR_WIDTH:0]   wptr,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic [ADDR_WIDTH:0]   rptr,
    output logic                  rempty,
    output logic                  raempty,
    output logic [ADDR_WIDTH:0]   rcount,
    output logic                  runderflow
);

    localparam int            PW    = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AE_TH = PW'(AEMPTY_THRESH);

    logic [PW-1:0] rq2_wptr;
    logic [PW-1:0] rbin;
    logic [PW-1:0] rbinnext;
    logic [PW-1:0] rgraynext;
    logic [PW-1:0] wbin_sync;
    logic [PW-1:0] cnt_next;
    logic          rpop;

    sync_w2r_ah #(
        .WIDTH (PW)
    ) u_sync (
        .rclk     (rclk),
        .rrst     (rrst),
        .wptr     (wptr),
        .rq2_wptr (rq2_wptr)
    );

    // Fill count is taken against the post-pop pointer so flags track the edge that consumes data.
    always_comb begin
        rpop      = rinc & ~rempty;
        rbinnext  = rbin + PW'(rpop);
        rgraynext = PW'(bin2gray(PTR_MAX_W'(rbinnext)));
        wbin_sync = PW'(gray2bin(PTR_MAX_W'(rq2_wptr)));
        cnt_next  = wbin_sync - rbinnext;
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin       <= '0;
            rptr       <= '0;
            rempty     <= 1'b1;
            raempty    <= 1'b1;
            rcount     <= '0;
            runderflow <= 1'b0;
        end else begin
            rbin    <= rbinnext;
            rptr    <= rgraynext;
            rempty  <= (rgraynext == rq2_wptr);
            rcount  <= cnt_next;
            raempty <= (cnt_next <= AE_TH);
            // A new underflow outranks a simultaneous clear.
            if (rinc && rempty) begin
                runderflow <= 1'b1;
            end else if (rclr_err) begin
                runderflow <= 1'b0;
            end
        end
    end

    assign raddr = rbin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl (ADDR_WIDTH=4, AEMPTY_THRESH=2) with an integer-count reference model.
module tb_fifo_rd_ctrl;

    localparam int AW = 4;
    localparam int TH = 2;

    logic          rclk;
    logic          rrst;
    logic          rinc;
    logic          rclr_err;
    logic [AW:0]   wptr;
    logic [AW-1:0] raddr;
    logic [AW:0]   rptr;
    logic          rempty;
    logic          raempty;
    logic [AW:0]   rcount;
    logic          runderflow;
    logic          clk_en;

    typedef struct {
        int   rd;
        int   cnt;
        logic empty;
        logic aempty;
        logic under;
    } exp_t;

    exp_t exp_q[$];

    int n_total;
    int n_pass;

    // reference model state: read/write totals modulo 32 and a 2-deep sync delay line
    int   m_wr, m_s1, m_s2, m_rd, m_cnt;
    logic m_empty, m_aempty, m_under;

    fifo_rd_ctrl #(
        .ADDR_WIDTH    (AW),
        .AEMPTY_THRESH (TH)
    ) dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .rinc       (rinc),
        .rclr_err   (rclr_err),
        .wptr       (wptr),
        .raddr      (raddr),
        .rptr       (rptr),
        .rempty     (rempty),
        .raempty    (raempty),
        .rcount     (rcount),
        .runderflow (runderflow)
    );

    initial rclk = 1'b0;
    always begin
        #5;
        if (clk_en) rclk = ~rclk;
    end

    function automatic logic [AW:0] gray(input int b);
        int v;
        v = b & 31;
        return 5'(v ^ (v >> 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic model_reset();
        m_wr = 0; m_s1 = 0; m_s2 = 0; m_rd = 0; m_cnt = 0;
        m_empty = 1'b1; m_aempty = 1'b1; m_under = 1'b0;
    endtask

    task automatic set_wr(input int total);
        m_wr = total & 31;
        wptr = gray(m_wr);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rempty"},  32'(rempty),     32'd1);
        chk({tag, "_raempty"}, 32'(raempty),    32'd1);
        chk({tag, "_rptr"},    32'(rptr),       32'd0);
        chk({tag, "_raddr"},   32'(raddr),      32'd0);
        chk({tag, "_rcount"},  32'(rcount),     32'd0);
        chk({tag, "_runder"},  32'(runderflow), 32'd0);
    endtask

    // Drive one cycle of inputs, predict the post-edge outputs, then compare after the edge.
    task automatic step(input logic inc, input logic clr, input string tag);
        exp_t e;
        logic pop;
        rinc     = inc;
        rclr_err = clr;
        pop = inc & ~m_empty;
        if (inc && m_empty) m_under = 1'b1;
        else if (clr)       m_under = 1'b0;
        m_rd     = (m_rd + int'(pop)) & 31;
        m_cnt    = (m_s2 - m_rd) & 31;
        m_empty  = (m_cnt == 0);
        m_aempty = (m_cnt <= TH);
        m_s2 = m_s1;
        m_s1 = m_wr;
        e.rd = m_rd; e.cnt = m_cnt; e.empty = m_empty; e.aempty = m_aempty; e.under = m_under;
        exp_q.push_back(e);
        @(posedge rclk);
        #1;
        e = exp_q.pop_front();
        chk({tag, "_raddr"},   32'(raddr),      32'(e.rd & 15));
        chk({tag, "_rptr"},    32'(rptr),       32'(gray(e.rd)));
        chk({tag, "_rempty"},  32'(rempty),     32'(e.empty));
        chk({tag, "_raempty"}, 32'(raempty),    32'(e.aempty));
        chk({tag, "_rcount"},  32'(rcount),     32'(e.cnt));
        chk({tag, "_runder"},  32'(runderflow), 32'(e.under));
        rinc     = 1'b0;
        rclr_err = 1'b0;
    endtask

    initial begin
        int guard;
        n_total = 0; n_pass = 0;
        clk_en = 1'b0; rrst = 1'b0; rinc = 1'b0; rclr_err = 1'b0; wptr = '0;
        model_reset();

        // 1: reset with the clock stopped
        #3 rrst = 1'b1;
        #2 check_reset_outputs("t1_rst");
        #3 rrst = 1'b0;
        #4 clk_en = 1'b1;

        // 2: one entry written; visible after the third edge
        set_wr(1);
        step(0, 0, "t2_e1");
        chk("t2_still_empty_e1", 32'(rempty), 32'd1);
        step(0, 0, "t2_e2");
        chk("t2_still_empty_e2", 32'(rempty), 32'd1);
        step(0, 0, "t2_e3");
        chk("t2_nonempty_e3", 32'(rempty), 32'd0);
        chk("t2_count_e3",    32'(rcount), 32'd1);

        // 3: five entries, five back-to-back pops
        set_wr(5);
        for (int i = 0; i < 3; i++) step(0, 0, "t3_sync");
        chk("t3_count5", 32'(rcount), 32'd5);
        for (int i = 0; i < 5; i++) step(1, 0, "t3_pop");
        chk("t3_empty_after5", 32'(rempty), 32'd1);
        chk("t3_rptr_after5",  32'(rptr),   32'h7);

        // 4: underflow set, set-wins-over-clear, clear
        step(1, 0, "t4_under");
        chk("t4_rptr_hold", 32'(rptr), 32'h7);
        step(1, 1, "t4_setclr");
        step(0, 1, "t4_clr");
        chk("t4_cleared", 32'(runderflow), 32'd0);

        // 5: fill to 16, then 32 simultaneous write/pop rounds across the wrap
        set_wr(m_rd + 16);
        for (int i = 0; i < 3; i++) step(0, 0, "t5_fill");
        chk("t5_full_count", 32'(rcount), 32'd16);
        chk("t5_full_nonempty", 32'(rempty), 32'd0);
        for (int i = 0; i < 32; i++) begin
            set_wr(m_wr + 1);
            step(1, 0, "t5_round");
            if (m_rd == 0) chk("t5_wrap_rptr0", 32'(rptr), 32'd0);
        end
        chk("t5_no_false_empty", 32'(rempty), 32'd0);

        // 6: drain to 7, then asynchronous reset mid-burst
        guard = 0;
        while (m_cnt != 7 && guard < 40) begin
            step(1, 0, "t6_drain");
            guard++;
        end
        chk("t6_reached7", 32'(guard < 40), 32'd1);
        chk("t6_count7",   32'(rcount),     32'd7);
        rinc = 1'b1;
        #3 rrst = 1'b1;
        #1 check_reset_outputs("t6_async");
        wptr = '0;
        model_reset();
        @(negedge rclk);
        rrst = 1'b0;
        rinc = 1'b0;
        step(0, 0, "t6_post0");
        step(0, 0, "t6_post1");
        step(1, 0, "t6_nopop");
        chk("t6_rptr_zero", 32'(rptr), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
